// File: rtl/inv_key_sched.sv
// ---------------------------------------------------------------------------
// inv_key_sched
//   Produces the AES-128 decryption round keys in reverse order: round 10
//   (loaded from key_last) down to round 0 (the cipher key). Each step
//   reverses one forward key-expansion step. The reversal needs the forward
//   S-box only, applied to RotWord of the recovered w3. The inverse S-box is
//   never used.
//
// Ports
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   start       in   load request, honoured only in IDLE
//   key_last    in   round-10 key (w0 = [127:96] .. w3 = [31:0])
//   rkey        out  current round key
//   rkey_round  out  round index of rkey (10 .. 0)
//   rkey_valid  out  rkey / rkey_round valid
//   rkey_ready  in   consumer accepts the beat when valid & ready
//   busy        out  high whenever not IDLE
//   done        out  one-cycle pulse after the round-0 beat is accepted
//
// State | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; rkey keeps the last key produced
// OUT   | presenting rkey for round rkey_round, advancing on each accept
// ---------------------------------------------------------------------------

// RotWord followed by byte-wise forward S-box on a 32-bit word.
//   word_i  in   input word {b0,b1,b2,b3}
//   word_o  out  SubWord({b1,b2,b3,b0})
module aes_rot_sub (
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  logic [31:0] rot;

  assign rot    = {word_i[23:0], word_i[31:24]};
  assign word_o = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};

endmodule

module inv_key_sched #(
  // Only 10 is meaningful: the Rcon table below covers rounds 1..10.
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_last,
  output logic [127:0] rkey,
  output logic [3:0]   rkey_round,
  output logic         rkey_valid,
  input  logic         rkey_ready,
  output logic         busy,
  output logic         done
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_OUT  = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic         done_q, done_d;

  logic         accept;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  v0, v1, v2, v3;
  logic [31:0]  rs_v3;
  logic [127:0] prev_key;

  // Rcon for the expansion step that produced round i. Index 0 never
  // reaches the datapath because round 0 ends the sequence.
  function automatic logic [7:0] rcon(input logic [3:0] i);
    logic [7:0] r;
    case (i)
      4'd1:    r = 8'h01;
      4'd2:    r = 8'h02;
      4'd3:    r = 8'h04;
      4'd4:    r = 8'h08;
      4'd5:    r = 8'h10;
      4'd6:    r = 8'h20;
      4'd7:    r = 8'h40;
      4'd8:    r = 8'h80;
      4'd9:    r = 8'h1b;
      4'd10:   r = 8'h36;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // One inverse expansion step. The later words of the previous key are
  // recovered first because v3 is the word the forward step fed into
  // RotWord/SubWord.
  assign {w0, w1, w2, w3} = rkey_q;
  assign v3 = w3 ^ w2;
  assign v2 = w2 ^ w1;
  assign v1 = w1 ^ w0;

  aes_rot_sub u_rot_sub (
    .word_i (v3),
    .word_o (rs_v3)
  );

  assign v0       = w0 ^ rs_v3 ^ {rcon(round_q), 24'h0};
  assign prev_key = {v0, v1, v2, v3};

  assign accept = (state_q == S_OUT) && rkey_ready;

  // State register and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rkey_q  <= '0;
      round_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rkey_q  <= rkey_d;
      round_q <= round_d;
      done_q  <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_OUT;
      S_OUT:  if (accept && (round_q == 4'd0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values. start is only looked at in IDLE, so a start during
  // a sequence (including the final accept cycle) has no effect.
  always_comb begin
    rkey_d  = rkey_q;
    round_d = round_q;
    done_d  = 1'b0;
    if ((state_q == S_IDLE) && start) begin
      rkey_d  = key_last;
      round_d = 4'(NR);
    end else if (accept) begin
      if (round_q != 4'd0) begin
        rkey_d  = prev_key;
        round_d = round_q - 4'd1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  // Output logic
  always_comb begin
    rkey_valid = 1'b0;
    busy       = 1'b0;
    case (state_q)
      S_OUT: begin
        rkey_valid = 1'b1;
        busy       = 1'b1;
      end
      default: ;
    endcase
  end

  assign rkey       = rkey_q;
  assign rkey_round = round_q;
  assign done       = done_q;

endmodule

// File: tb/tb_inv_key_sched.sv
// Bench for inv_key_sched. The reference computes the forward AES-128 key
// expansion from a cipher key, with the S-box derived from GF(2^8) inversion
// plus the affine map. The DUT must emit that schedule in reverse.
module tb_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] key_last;
  logic [127:0] rkey;
  logic [3:0]   rkey_round;
  logic         rkey_valid;
  logic         rkey_ready;
  logic         busy;
  logic         done;

  inv_key_sched #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .key_last   (key_last),
    .rkey       (rkey),
    .rkey_round (rkey_round),
    .rkey_valid (rkey_valid),
    .rkey_ready (rkey_ready),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_CK   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_LAST = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_LAST = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   ref_sbox [256];
  logic [127:0] model_rk [11];
  logic [127:0] got      [11];
  int           last_cycles;

  typedef struct {
    logic [127:0] key;
    int           round;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    logic [15:0] s = d << n;
    return s[15:8];
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0) begin
        inv = 8'h01;
        for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      end
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  // Forward key expansion: model_rk[r] is the round-r key of cipher key ck.
  task automatic expand(input logic [127:0] ck);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    {w[0], w[1], w[2], w[3]} = ck;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {ref_sbox[t[31:24]], ref_sbox[t[23:16]], ref_sbox[t[15:8]], ref_sbox[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0;
    rkey_ready = 1'b0;
    key_last = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // mode 0: ready always high; 1: random ready, 3-cycle stall at round 9;
  // 2: ready high, start with a zero key pulsed at round 5.
  // last_start: also raise start (other key) in the final accept cycle.
  // Returns in the cycle that should carry done.
  task automatic run_seq(input logic [127:0] key, input int mode, input bit last_start);
    int         exp_round = 10;
    int         cyc = 0;
    int         stall = 0;
    int         n_acc = 0;
    bit         poked = 1'b0;
    bit         fin = 1'b0;
    bit         prev_stall = 1'b0;
    logic [127:0] prev_key = '0;
    logic [3:0]   prev_round = '0;
    for (int r = 0; r < 11; r++) got[r] = 'x;
    key_last = key;
    start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0;
    key_last = '0;
    chk("latency_valid", 128'(rkey_valid), 128'(1'b1));
    while (!fin && cyc < 400) begin
      if (prev_stall) begin
        chk("stall_key", rkey, prev_key);
        chk("stall_round", 128'(rkey_round), 128'(prev_round));
      end
      if (mode == 1 && rkey_round == 4'd9 && stall < 3) begin
        rkey_ready = 1'b0;
        stall++;
      end else if (mode == 1) begin
        rkey_ready = 1'($urandom_range(0, 1));
      end else begin
        rkey_ready = 1'b1;
      end
      if (mode == 2 && rkey_round == 4'd5 && !poked) begin
        start = 1'b1;
        key_last = '0;
        poked = 1'b1;
      end
      if (last_start && rkey_round == 4'd0 && rkey_valid && rkey_ready) begin
        start = 1'b1;
        key_last = ~key;
      end
      if (rkey_valid && rkey_ready) begin
        chk("beat_order", 128'(rkey_round), 128'(exp_round));
        if (rkey_round <= 4'd10) got[rkey_round] = rkey;
        n_acc++;
        exp_round--;
        if (rkey_round == 4'd0) fin = 1'b1;
      end
      prev_stall = rkey_valid && !rkey_ready;
      prev_key = rkey;
      prev_round = rkey_round;
      step();
      cyc++;
      start = 1'b0;
      key_last = '0;
    end
    last_cycles = cyc;
    if (!fin) begin
      n_tests++;
      n_fail++;
      $display("FAIL seq_timeout: got %0d beats expected 11", n_acc);
    end else begin
      chk("beat_count", 128'(n_acc), 128'(11));
      chk("done_pulse", 128'(done), 128'(1'b1));
      chk("done_valid_low", 128'(rkey_valid), 128'(1'b0));
      chk("done_busy_low", 128'(busy), 128'(1'b0));
    end
  endtask

  task automatic check_all(input string name);
    for (int r = 0; r < 11; r++) chk($sformatf("%s_r%0d", name, r), got[r], model_rk[r]);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    key_last = '0;
    rkey_ready = 1'b0;
    init_sbox();

    vecs[0] = '{key: FIPS_LAST, round: 10, exp: FIPS_LAST};
    vecs[1] = '{key: FIPS_LAST, round: 9,  exp: 128'hac7766f319fadc2128d12941575c006e};
    vecs[2] = '{key: FIPS_LAST, round: 1,  exp: 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[3] = '{key: FIPS_LAST, round: 0,  exp: FIPS_CK};
    vecs[4] = '{key: ZERO_LAST, round: 1,  exp: 128'h62636363626363636263636362636363};
    vecs[5] = '{key: ZERO_LAST, round: 0,  exp: 128'h0};

    // Reset state
    do_reset();
    rst_n = 1'b0;
    step();
    chk("rst_valid", 128'(rkey_valid), 128'(1'b0));
    chk("rst_busy", 128'(busy), 128'(1'b0));
    chk("rst_done", 128'(done), 128'(1'b0));
    chk("rst_rkey", rkey, 128'h0);
    chk("rst_round", 128'(rkey_round), 128'h0);
    rst_n = 1'b1;
    step();

    // Known-answer vectors, ready held high
    for (int v = 0; v < 6; v++) begin
      run_seq(vecs[v].key, 0, 1'b0);
      chk($sformatf("vec%0d_r%0d", v, vecs[v].round), got[vecs[v].round], vecs[v].exp);
      chk($sformatf("vec%0d_cycles", v), 128'(last_cycles), 128'(12));
      chk($sformatf("vec%0d_rkey_hold", v), rkey, vecs[v].key == FIPS_LAST ? FIPS_CK : 128'h0);
      rkey_ready = 1'b0;
      step();
      chk($sformatf("vec%0d_done_fall", v), 128'(done), 128'(1'b0));
    end

    // Backpressure with a forced stall at round 9
    expand(FIPS_CK);
    run_seq(FIPS_LAST, 1, 1'b0);
    check_all("bp");
    step();

    // start while busy is ignored
    run_seq(FIPS_LAST, 2, 1'b0);
    check_all("busy_start");
    step();

    // Reset mid-sequence at round 6
    begin
      int guard = 0;
      key_last = FIPS_LAST;
      start = 1'b1;
      step();
      start = 1'b0;
      rkey_ready = 1'b1;
      while (rkey_round != 4'd6 && guard < 20) begin
        step();
        guard++;
      end
      chk("mid_reached_r6", 128'(rkey_round), 128'(6));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("mid_rst_valid", 128'(rkey_valid), 128'(1'b0));
      chk("mid_rst_busy", 128'(busy), 128'(1'b0));
      chk("mid_rst_rkey", rkey, 128'h0);
      chk("mid_rst_done", 128'(done), 128'(1'b0));
      for (int k = 0; k < 3; k++) begin
        step();
        chk("mid_no_done", 128'(done), 128'(1'b0));
      end
      key_last = FIPS_LAST;
      start = 1'b1;
      step();
      start = 1'b0;
      chk("mid_restart_round", 128'(rkey_round), 128'(10));
      chk("mid_restart_key", rkey, FIPS_LAST);
      do_reset();
    end

    // Zero key; start in the final accept cycle is ignored, start in the
    // done cycle is taken and round 10 appears one cycle later.
    expand(128'h0);
    run_seq(ZERO_LAST, 0, 1'b1);
    check_all("zero");
    chk("zero_done_rkey", rkey, 128'h0);
    key_last = FIPS_LAST;
    start = 1'b1;
    rkey_ready = 1'b0;
    step();
    start = 1'b0;
    chk("b2b_valid", 128'(rkey_valid), 128'(1'b1));
    chk("b2b_round", 128'(rkey_round), 128'(10));
    chk("b2b_key", rkey, FIPS_LAST);
    chk("b2b_done_fall", 128'(done), 128'(1'b0));
    do_reset();

    // Random cipher keys against the forward-expansion model
    for (int n = 0; n < 8; n++) begin
      logic [127:0] ck;
      ck = {$urandom, $urandom, $urandom, $urandom};
      expand(ck);
      run_seq(model_rk[10], 1, n[0]);
      check_all($sformatf("rnd%0d", n));
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
